// File: rtl/pa_spsram_1024x4_ctrl_if.sv
// Client-side request/response bus of the 1024x4 SRAM access controller.
// The client drives requests and accepts read data; the controller is the slave.
interface pa_spsram_1024x4_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4
) ();

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface

// File: rtl/pa_spsram_1024x4_ctrl.sv
// Access controller for the 1024x4 single-port SRAM wrapper.
// Clears the array to INIT_VAL after reset or on request, then serves
// single-beat reads/writes from a valid/ready client. SRAM pins are driven
// combinationally from the accepted request; read data comes straight from Q.
module pa_spsram_1024x4_ctrl #(
  parameter int                     ADDR_WIDTH = 10,
  parameter int                     DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]  INIT_VAL   = 4'h0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  pa_spsram_1024x4_ctrl_if.slave bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  clear_pend_q, clear_pend_d;
  logic                  init_done_q, init_done_d;

  logic                  req_rdy_s;
  logic                  rsp_stall_s;
  logic                  xfer_s;
  logic                  cen_s;
  logic                  gwen_s;
  logic [DATA_WIDTH-1:0] wen_s;
  logic [ADDR_WIDTH-1:0] a_s;
  logic [DATA_WIDTH-1:0] d_s;

  // State register: sweep counter, response valid, pending clear, init flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_INIT;
      cnt_q        <= CNT_ZERO;
      rsp_vld_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_vld_q    <= rsp_vld_d;
      clear_pend_q <= clear_pend_d;
      init_done_q  <= init_done_d;
    end
  end

  // Next-state and SRAM pin decode; pins idle (CEN=1) unless an access is made.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_vld_d    = rsp_vld_q;
    clear_pend_d = clear_pend_q;
    init_done_d  = init_done_q;
    req_rdy_s    = 1'b0;
    rsp_stall_s  = rsp_vld_q && !bus.rsp_rdy;
    xfer_s       = 1'b0;
    cen_s        = 1'b1;
    gwen_s       = 1'b1;
    wen_s        = ALL_ONES;
    a_s          = bus.req_addr;
    d_s          = bus.req_wdata;

    if (RST) begin
      // Reset keeps the SRAM idle; the register block restores state.
      req_rdy_s = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Clear sweep: one full-word write per cycle; clr_req is ignored here.
          cen_s  = 1'b0;
          gwen_s = 1'b0;
          wen_s  = ALL_ZERO;
          a_s    = cnt_q;
          d_s    = INIT_VAL;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            state_d     = ST_INIT;
          end
        end
        ST_RUN: begin
          // A stalled response or any clear request blocks new transfers,
          // which also keeps Q (and rsp_rdata) stable during backpressure.
          req_rdy_s = !rsp_stall_s && !clear_pend_q && !clr_req;
          xfer_s    = bus.req_vld && req_rdy_s;
          if (xfer_s) begin
            cen_s = 1'b0;
            if (bus.req_wr) begin
              gwen_s = 1'b0;
              wen_s  = ~bus.req_wmask;
            end else begin
              gwen_s = 1'b1;
              wen_s  = ALL_ONES;
            end
          end else begin
            cen_s = 1'b1;
          end

          if (xfer_s && !bus.req_wr) begin
            rsp_vld_d = 1'b1;
          end else if (bus.rsp_rdy) begin
            rsp_vld_d = 1'b0;
          end else begin
            rsp_vld_d = rsp_vld_q;
          end

          if (clear_pend_q && !rsp_stall_s) begin
            // Outstanding response drains this cycle; restart the sweep.
            state_d      = ST_INIT;
            cnt_d        = CNT_ZERO;
            init_done_d  = 1'b0;
            clear_pend_d = 1'b0;
            rsp_vld_d    = 1'b0;
          end else begin
            clear_pend_d = clear_pend_q || clr_req;
          end
        end
        default: begin
          state_d     = ST_INIT;
          cnt_d       = CNT_ZERO;
          init_done_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy   = req_rdy_s;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_rdata = Q;
  assign init_done     = init_done_q;
  assign A             = a_s;
  assign CEN           = cen_s;
  assign GWEN          = gwen_s;
  assign WEN           = wen_s;
  assign D             = d_s;

endmodule

// File: tb/tb_pa_spsram_1024x4_ctrl.sv
// Directed bench for pa_spsram_1024x4_ctrl with a behavioural SRAM model.
// Read expectations are queued when a read is accepted; a monitor pops and
// compares whenever a response handshake occurs.
module tb_pa_spsram_1024x4_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       clr_req = 1'b0;
  logic       init_done;
  logic [9:0] A;
  logic       CEN;
  logic       GWEN;
  logic [3:0] WEN;
  logic [3:0] D;
  logic [3:0] Q;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic [3:0] mem [0:1023];

  pa_spsram_1024x4_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(4)) bus ();

  pa_spsram_1024x4_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .INIT_VAL(4'h0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clr_req   (clr_req),
    .bus       (bus),
    .init_done (init_done),
    .A         (A),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .D         (D),
    .Q         (Q)
  );

  always #5 CLK = ~CLK;

  // SRAM model: per-bit masked write, Q updates only on a read access.
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q <= mem[A];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  // Response monitor: compare every accepted beat against the queue head.
  always @(negedge CLK) begin
    if (!RST && bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp_rdata", {28'd0, bus.rsp_rdata}, {28'd0, mon_exp});
      end
    end
  end

  // Checks a full 1024-cycle sweep starting at the current cycle.
  task automatic sweep_check(input string name);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      #3;
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 4'h0 || A !== i[9:0] ||
          D !== 4'h0 || bus.req_rdy !== 1'b0 || init_done !== 1'b0) begin
        if (bad == 0)
          $display("sweep %s first bad cycle %0d: A=%0h CEN=%b GWEN=%b WEN=%h D=%h rdy=%b done=%b",
                   name, i, A, CEN, GWEN, WEN, D, bus.req_rdy, init_done);
        bad++;
      end
      next();
    end
    chk({name, "_bad_cycles"}, bad, 32'd0);
    #3;
    chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    chk({name, "_rdy_after"}, {31'd0, bus.req_rdy}, 32'd1);
    next();
  endtask

  task automatic wr(input logic [9:0] addr, input logic [3:0] data, input logic [3:0] mask);
    bus.req_vld = 1'b1; bus.req_wr = 1'b1;
    bus.req_addr = addr; bus.req_wdata = data; bus.req_wmask = mask;
    #3;
    chk("wr_rdy",  {31'd0, bus.req_rdy}, 32'd1);
    chk("wr_cen",  {31'd0, CEN},  32'd0);
    chk("wr_gwen", {31'd0, GWEN}, 32'd0);
    chk("wr_a",    {22'd0, A},    {22'd0, addr});
    chk("wr_wen",  {28'd0, WEN},  {28'd0, ~mask});
    chk("wr_d",    {28'd0, D},    {28'd0, data});
    next();
    bus.req_vld = 1'b0;
  endtask

  task automatic rd(input logic [9:0] addr, input logic [3:0] exp);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = addr;
    #3;
    chk("rd_rdy",  {31'd0, bus.req_rdy}, 32'd1);
    chk("rd_cen",  {31'd0, CEN},  32'd0);
    chk("rd_gwen", {31'd0, GWEN}, 32'd1);
    chk("rd_wen",  {28'd0, WEN},  32'hF);
    chk("rd_a",    {22'd0, A},    {22'd0, addr});
    exp_q.push_back(exp);
    next();
    bus.req_vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 1024; i++) mem[i] = 4'h9;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 10'd0;
    bus.req_wdata = 4'h0; bus.req_wmask = 4'h0; bus.rsp_rdy = 1'b1;

    // Reset held for three edges.
    next();
    #3;
    chk("rst_cen",       {31'd0, CEN},  32'd1);
    chk("rst_gwen",      {31'd0, GWEN}, 32'd1);
    chk("rst_wen",       {28'd0, WEN},  32'hF);
    chk("rst_rdy",       {31'd0, bus.req_rdy}, 32'd0);
    chk("rst_init_done", {31'd0, init_done},   32'd0);
    chk("rst_rsp_vld",   {31'd0, bus.rsp_vld}, 32'd0);
    next();
    next();
    RST = 1'b0;
    sweep_check("sweep0");

    // Write then read back-to-back.
    wr(10'h155, 4'hA, 4'hF);
    rd(10'h155, 4'hA);
    #3;
    chk("rd_latency", {31'd0, bus.rsp_vld}, 32'd1);
    next();
    #3;
    chk("rsp_clear", {31'd0, bus.rsp_vld}, 32'd0);
    next();

    // Partial mask write over cleared word.
    wr(10'd7, 4'hF, 4'b0101);
    rd(10'd7, 4'h5);
    next();

    // Backpressure: response stalls, pending read attempt must not issue.
    bus.rsp_rdy = 1'b0;
    rd(10'd7, 4'h5);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 10'd0;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("stall_vld",   {31'd0, bus.rsp_vld},   32'd1);
      chk("stall_rdata", {28'd0, bus.rsp_rdata}, 32'h5);
      chk("stall_rdy",   {31'd0, bus.req_rdy},   32'd0);
      chk("stall_cen",   {31'd0, CEN},           32'd1);
      next();
    end
    bus.req_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    #3;
    chk("bp_release_vld", {31'd0, bus.rsp_vld}, 32'd1);
    next();
    #3;
    chk("bp_drop", {31'd0, bus.rsp_vld}, 32'd0);
    next();

    // Re-clear while a response is stalled.
    bus.rsp_rdy = 1'b0;
    rd(10'd7, 4'h5);
    clr_req = 1'b1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 10'd3;
    #3;
    chk("clr_rdy", {31'd0, bus.req_rdy}, 32'd0);
    chk("clr_cen", {31'd0, CEN},         32'd1);
    next();
    clr_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("pend_rdy",  {31'd0, bus.req_rdy}, 32'd0);
      chk("pend_cen",  {31'd0, CEN},         32'd1);
      chk("pend_done", {31'd0, init_done},   32'd1);
      next();
    end
    bus.rsp_rdy = 1'b1;
    #3;
    chk("pend_drain_rdy", {31'd0, bus.req_rdy}, 32'd0);
    next();
    bus.req_vld = 1'b0;
    sweep_check("sweep1");
    rd(10'd7, 4'h0);
    next();

    // Reset in the middle of a sweep.
    wr(10'h155, 4'h6, 4'hF);
    clr_req = 1'b1;
    #3;
    chk("c6_rdy", {31'd0, bus.req_rdy}, 32'd0);
    next();
    clr_req = 1'b0;
    next();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      #3;
      if (CEN !== 1'b0 || A !== i[9:0]) bad++;
      next();
    end
    chk("mid_sweep_bad", bad, 32'd0);
    #3;
    chk("mid_a500", {22'd0, A}, 32'd500);
    RST = 1'b1;
    #1;
    chk("mid_rst_cen",  {31'd0, CEN},  32'd1);
    chk("mid_rst_gwen", {31'd0, GWEN}, 32'd1);
    chk("mid_rst_wen",  {28'd0, WEN},  32'hF);
    next();
    #3;
    chk("mid_rst_cen2", {31'd0, CEN},       32'd1);
    chk("mid_rst_done", {31'd0, init_done}, 32'd0);
    next();
    RST = 1'b0;
    sweep_check("sweep2");
    rd(10'h155, 4'h0);
    next();
    next();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
